// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
//   Signal bundle between the ALU op sequencer and its surroundings.
//   Three groups:
//     cmd_*  : command handshake from the issue logic
//              (valid/ready, opcode, count, operands).
//     alu_*  : operand/opcode/execute stream to the ALU, plus its result and
//              flags coming back.
//     rsp_*  : result handshake to the consumer (valid/ready, data, {S,C,Z}).
//   Optional: abort (present only when ALU_SEQ_ABORT_EN is defined).
//   Modports:
//     master : the sequencer's view. It drives cmd_ready, alu_A/B/op/execute
//              and rsp_valid/data/flags.
//     slave  : the environment's view (issue logic, ALU, consumer).
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int BITS     = 16,
    parameter int CNT_BITS = 4
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [4:0]          cmd_op;
    logic [CNT_BITS-1:0] cmd_count;
    logic [BITS-1:0]     cmd_a;
    logic [BITS-1:0]     cmd_b;

    logic [BITS-1:0]     alu_A;
    logic [BITS-1:0]     alu_B;
    logic [4:0]          alu_op;
    logic                alu_execute;
    logic [BITS-1:0]     alu_out;
    logic                alu_C;
    logic                alu_Z;
    logic                alu_S;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [BITS-1:0]     rsp_data;
    logic [2:0]          rsp_flags;

`ifdef ALU_SEQ_ABORT_EN
    logic                abort;

    modport master (
        input  cmd_valid, cmd_op, cmd_count, cmd_a, cmd_b,
        input  alu_out, alu_C, alu_Z, alu_S, rsp_ready, abort,
        output cmd_ready, alu_A, alu_B, alu_op, alu_execute,
        output rsp_valid, rsp_data, rsp_flags
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_count, cmd_a, cmd_b,
        output alu_out, alu_C, alu_Z, alu_S, rsp_ready, abort,
        input  cmd_ready, alu_A, alu_B, alu_op, alu_execute,
        input  rsp_valid, rsp_data, rsp_flags
    );
`else
    modport master (
        input  cmd_valid, cmd_op, cmd_count, cmd_a, cmd_b,
        input  alu_out, alu_C, alu_Z, alu_S, rsp_ready,
        output cmd_ready, alu_A, alu_B, alu_op, alu_execute,
        output rsp_valid, rsp_data, rsp_flags
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_count, cmd_a, cmd_b,
        output alu_out, alu_C, alu_Z, alu_S, rsp_ready,
        input  cmd_ready, alu_A, alu_B, alu_op, alu_execute,
        input  rsp_valid, rsp_data, rsp_flags
    );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//   Command-side driver for the 16-bit flag-holding ALU.
//   - Accepts one command per cmd valid/ready handshake.
//   - Single-bit shift/rotate ops (16..20) repeat N times. Each result is fed
//     back as the next operand, which gives multi-bit shifts without a barrel
//     shifter.
//   - Returns the final ALU result and {S,C,Z} over the rsp handshake.
//
//   Ports:
//     CLK  : clock
//     RSTb : asynchronous active-low reset
//     bus  : alu_op_sequencer_if.master, carrying the cmd_*, alu_* and rsp_*
//            groups
//
//   Optional feature: define ALU_SEQ_ABORT_EN to add bus.abort. When abort
//   is high in RUN or WAIT, the command is dropped and the block returns to
//   IDLE without issuing a response.
//
//   Timing: a command accepted in cycle T drives execute pulses in cycles
//   T+1..T+N, and rsp_valid first rises in cycle T+N+2.
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int BITS     = 16,
    parameter int CNT_BITS = 4
) (
    input  logic               CLK,
    input  logic               RSTb,
    alu_op_sequencer_if.master bus
);
    // One extra bit so that a count of 0 can hold 2**CNT_BITS steps.
    localparam int STEP_BITS = CNT_BITS + 1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t               state;
    logic [4:0]           opReg;
    logic [BITS-1:0]      aReg;
    logic [BITS-1:0]      bReg;
    logic [STEP_BITS-1:0] stepsReg;
    logic                 firstReg;
    logic                 execReg;
    logic                 cmdReadyReg;
    logic                 rspValidReg;
    logic [BITS-1:0]      rspDataReg;
    logic [2:0]           rspFlagsReg;

    logic                 isRepeat;
    logic                 feedback;
    logic                 abortReq;
    logic [STEP_BITS-1:0] loadSteps;

`ifdef ALU_SEQ_ABORT_EN
    assign abortReq = bus.abort;
`else
    assign abortReq = 1'b0;
`endif

    assign isRepeat  = (bus.cmd_op >= 5'd16) && (bus.cmd_op <= 5'd20);
    assign loadSteps = !isRepeat                   ? STEP_BITS'(1) :
                       (bus.cmd_count == '0)       ? STEP_BITS'(1 << CNT_BITS) :
                                                     {1'b0, bus.cmd_count};

    // After the first step, both operands come straight from the ALU result.
    // Both A and B are fed back because rolc/rorc take their carry-in from A.
    assign feedback = (state == RUN) && !firstReg;

    assign bus.alu_A       = feedback ? bus.alu_out : aReg;
    assign bus.alu_B       = feedback ? bus.alu_out : bReg;
    assign bus.alu_op      = opReg;
    assign bus.alu_execute = execReg;
    assign bus.cmd_ready   = cmdReadyReg;
    assign bus.rsp_valid   = rspValidReg;
    assign bus.rsp_data    = rspDataReg;
    assign bus.rsp_flags   = rspFlagsReg;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state       <= IDLE;
            opReg       <= '0;
            aReg        <= '0;
            bReg        <= '0;
            stepsReg    <= '0;
            firstReg    <= 1'b0;
            execReg     <= 1'b0;
            cmdReadyReg <= 1'b1;
            rspValidReg <= 1'b0;
            rspDataReg  <= '0;
            rspFlagsReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmdReadyReg) begin
                        opReg       <= bus.cmd_op;
                        aReg        <= bus.cmd_a;
                        bReg        <= bus.cmd_b;
                        stepsReg    <= loadSteps;
                        firstReg    <= 1'b1;
                        execReg     <= 1'b1;
                        cmdReadyReg <= 1'b0;
                        state       <= RUN;
                    end
                end

                RUN: begin
                    // Keep the operands presented in this step. The ALU bus
                    // then holds its last values once the run ends or is
                    // aborted.
                    aReg     <= bus.alu_A;
                    bReg     <= bus.alu_B;
                    firstReg <= 1'b0;
                    if (abortReq) begin
                        execReg     <= 1'b0;
                        cmdReadyReg <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        stepsReg <= stepsReg - STEP_BITS'(1);
                        if (stepsReg == STEP_BITS'(1)) begin
                            execReg <= 1'b0;
                            state   <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (abortReq) begin
                        cmdReadyReg <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        // The ALU registers its result, so the final step's
                        // output is valid here, one cycle after the last
                        // execute.
                        rspDataReg  <= bus.alu_out;
                        rspFlagsReg <= {bus.alu_S, bus.alu_C, bus.alu_Z};
                        rspValidReg <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (bus.rsp_ready) begin
                        rspValidReg <= 1'b0;
                        cmdReadyReg <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    logic CLK;
    logic RSTb;
    int   total = 0;
    int   bad   = 0;

    alu_op_sequencer_if #(.BITS(16), .CNT_BITS(4)) bus ();

    alu_op_sequencer #(.BITS(16), .CNT_BITS(4)) dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Small ALU model. The result and flags are registered on execute.
    //   1 add | 16 asr | 17 lsr | 18 lsl | 19 rolc | 20 rorc | 23 clear carry
    logic [15:0] mOut, nOut;
    logic        mC, mZ, mS, nC, nZ, nS;

    always_comb begin
        nOut = mOut;
        nC   = mC;
        case (bus.alu_op)
            5'd1:  {nC, nOut} = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
            5'd16: begin nOut = {bus.alu_B[15], bus.alu_B[15:1]}; nC = bus.alu_B[0];  end
            5'd17: begin nOut = {1'b0, bus.alu_B[15:1]};          nC = bus.alu_B[0];  end
            5'd18: begin nOut = {bus.alu_B[14:0], 1'b0};          nC = bus.alu_B[15]; end
            5'd19: begin nOut = {bus.alu_B[14:0], mC};            nC = bus.alu_B[15]; end
            5'd20: begin nOut = {mC, bus.alu_B[15:1]};            nC = bus.alu_B[0];  end
            5'd23: nC = 1'b0;
            default: ;
        endcase
        nZ = (bus.alu_op == 5'd23) ? mZ : (nOut == 16'h0000);
        nS = (bus.alu_op == 5'd23) ? mS : nOut[15];
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            mOut <= '0; mC <= 1'b0; mZ <= 1'b0; mS <= 1'b0;
        end else if (bus.alu_execute) begin
            mOut <= nOut; mC <= nC; mZ <= nZ; mS <= nS;
        end
    end

    assign bus.alu_out = mOut;
    assign bus.alu_C   = mC;
    assign bus.alu_Z   = mZ;
    assign bus.alu_S   = mS;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, check the pulse count, response latency and result,
    // then hold rsp_ready low for 'hold' cycles before the handshake.
    task automatic runCmd(input string tag, input logic [4:0] op, input logic [3:0] cnt,
                          input logic [15:0] a, input logic [15:0] b, input int n,
                          input logic [15:0] expData, input logic [2:0] expFlags,
                          input int hold);
        int pulsesIn  = 0;
        int pulsesOut = 0;
        int readyHigh = 0;
        int rspAt     = 0;
        chk({tag, ".ready_before"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.rsp_valid) begin
                rspAt = k;
                break;
            end
            if (bus.alu_execute) begin
                if (k <= n) pulsesIn++;
                else        pulsesOut++;
            end
            if (bus.cmd_ready) readyHigh++;
            tick();
        end
        chk({tag, ".pulses"}, 32'(pulsesIn), 32'(n));
        chk({tag, ".stray_pulses"}, 32'(pulsesOut), 32'd0);
        chk({tag, ".rsp_cycle"}, 32'(rspAt), 32'(n + 2));
        chk({tag, ".ready_busy"}, 32'(readyHigh), 32'd0);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(expData));
            chk({tag, ".rsp_flags"}, 32'(bus.rsp_flags), 32'(expFlags));
            chk({tag, ".ready_done"}, 32'(bus.cmd_ready), 32'd0);
            if (h == hold) bus.rsp_ready = 1'b1;
            else           tick();
        end
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, ".ready_after"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, ".valid_after"}, 32'(bus.rsp_valid), 32'd0);
        $display("txn %s op=%0d count=%0d a=%04h b=%04h pulses=%0d rsp_cycle=%0d data=%04h flags=%03b",
                 tag, op, cnt, a, b, pulsesIn, rspAt, expData, expFlags);
    endtask

    initial begin
        int seen;
        RSTb          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_count = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        bus.abort     = 1'b0;
`endif
        tick();
        chk("reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset.execute", 32'(bus.alu_execute), 32'd0);
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset.rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("reset.rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("reset.alu_A", 32'(bus.alu_A), 32'd0);
        chk("reset.alu_op", 32'(bus.alu_op), 32'd0);
        tick();
        RSTb = 1'b1;
        tick();

        // lsl x4 of 0x0001 -> 0x0010. Flags {S,C,Z} = 000.
        runCmd("lsl4", 5'd18, 4'd4, 16'h0000, 16'h0001, 4, 16'h0010, 3'b000, 0);
        // The ALU bus holds the operands of the last step (0x0008) and the op.
        chk("lsl4.hold_B", 32'(bus.alu_B), 32'h0008);
        chk("lsl4.hold_op", 32'(bus.alu_op), 32'd18);
        chk("lsl4.idle_exec", 32'(bus.alu_execute), 32'd0);

        // add ignores the count: 3 + 4 = 7 in a single pulse.
        runCmd("add", 5'd1, 4'd9, 16'h0003, 16'h0004, 1, 16'h0007, 3'b000, 0);

        // clear carry leaves the result at 7 and C = 0.
        runCmd("clc", 5'd23, 4'd0, 16'h0000, 16'h0000, 1, 16'h0007, 3'b000, 0);

        // rorc x16 through carry = 17-bit rotate left by 1: 0x8001, C=0 -> 0x0002, C=1.
        runCmd("rorc16", 5'd20, 4'd0, 16'h0000, 16'h8001, 16, 16'h0002, 3'b010, 0);

        // lsr x1 of 0xFFFF -> 0x7FFF, C=1. The response is held 4 cycles.
        runCmd("lsr_hold", 5'd17, 4'd1, 16'h0000, 16'hFFFF, 1, 16'h7FFF, 3'b010, 3);

        // Reset during step 3 of an 8-step asr.
        bus.cmd_op    = 5'd16;
        bus.cmd_count = 4'd8;
        bus.cmd_b     = 16'h8000;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid.step3_exec", 32'(bus.alu_execute), 32'd1);
        RSTb = 1'b0;
        #1;
        chk("rst_mid.exec_drop", 32'(bus.alu_execute), 32'd0);
        chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        tick();
        RSTb = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.rsp_valid || bus.alu_execute) seen++;
            tick();
        end
        chk("rst_mid.quiet", 32'(seen), 32'd0);
        chk("rst_mid.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        $display("txn rst_mid op=16 count=8 b=8000 reset in step 3");

`ifdef ALU_SEQ_ABORT_EN
        // Abort during step 2 of a 5-step lsl.
        bus.cmd_op    = 5'd18;
        bus.cmd_count = 4'd5;
        bus.cmd_b     = 16'h0001;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("abort.step2_exec", 32'(bus.alu_execute), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort.exec_drop", 32'(bus.alu_execute), 32'd0);
        chk("abort.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.rsp_valid || bus.alu_execute) seen++;
            tick();
        end
        chk("abort.quiet", 32'(seen), 32'd0);
        $display("txn abort op=18 count=5 b=0001 aborted in step 2");
        runCmd("post_abort", 5'd18, 4'd2, 16'h0000, 16'h0003, 2, 16'h000C, 3'b000, 0);
`endif

        // Back-to-back after reset: lsl x2 of 0x0003 -> 0x000C.
        runCmd("lsl2", 5'd18, 4'd2, 16'h0000, 16'h0003, 2, 16'h000C, 3'b000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side driver for the 16-bit flag-holding ALU. It generates the operand, opcode and execute-strobe stream that the ALU consumes, and collects the result.
- Accepts one command per valid/ready handshake. Repeatable single-bit shift/rotate ops (16..20) expand into N back-to-back ALU execute pulses, feeding each result back as the next operand.
- Returns the final aluOut and the C/Z/S flags over a response handshake.
- Sits between the instruction decode/issue logic and the ALU; gives the ALU multi-bit shifts without a barrel shifter.

Parameters:
- BITS, 16, datapath width; must match the ALU.
- CNT_BITS, 4, width of the repeat count. Count 0 means 2**CNT_BITS steps.

Ports:
- CLK  input  1  clock.
- RSTb  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  5  ALU opcode.
- cmd_count  input  CNT_BITS  repeat count; used only for ops 16..20.
- cmd_a  input  BITS  operand A.
- cmd_b  input  BITS  operand B.
- alu_A  output  BITS  to ALU A.
- alu_B  output  BITS  to ALU B.
- alu_op  output  5  to ALU aluOp.
- alu_execute  output  1  to ALU execute.
- alu_out  input  BITS  from ALU aluOut (registered in the ALU, valid the cycle after execute).
- alu_C, alu_Z, alu_S  input  1 each  ALU flags.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  BITS  final result.
- rsp_flags  output  3  {S,C,Z} captured with the result.

Behaviour:
- Reset (async, RSTb=0): state IDLE; cmd_ready=1; alu_execute=0; rsp_valid=0; rsp_data=0; rsp_flags=0; alu_A/alu_B/alu_op=0; internal registers cleared. Reset asserted mid-run drops alu_execute immediately, discards the command and produces no response.
- States: IDLE, RUN, WAIT, DONE.
- cmd_ready=1 only in IDLE.
- IDLE: on cmd_valid&cmd_ready, latch op/a/b and load steps.
  - steps = cmd_count for ops 16..20; cmd_count=0 loads 2**CNT_BITS.
  - steps = 1 for all other ops; count ignored.
  - Next state RUN.
- RUN: alu_execute=1 every cycle, alu_op = latched op.
  - First step: alu_A = latched a, alu_B = latched b.
  - Later steps: alu_A = alu_B = alu_out (combinational feedback), because rolc/rorc take carry-in from A.
  - steps decrements each cycle. When the step with steps==1 executes, next state is WAIT.
- WAIT: alu_execute=0. Capture rsp_data <= alu_out and rsp_flags <= {alu_S,alu_C,alu_Z}. Next state DONE.
- DONE: rsp_valid=1. rsp_data/rsp_flags are held stable while rsp_ready=0. On rsp_ready go to IDLE.
- Back-to-back: a new command can be accepted the cycle after the response handshake.
- Latency: accept at cycle T; execute pulses at T+1..T+N; rsp_valid first high at T+N+2.
- alu_execute is never high outside RUN. alu_A/alu_B/alu_op hold their last values when idle.

Optional Feature:
- ALU_SEQ_ABORT_EN defined: adds input abort (1 bit).
  - abort=1 in RUN or WAIT: next state IDLE, alu_execute=0 from the next cycle, no response issued. The ALU keeps whatever steps already executed.
  - abort is ignored in IDLE and DONE.
- ALU_SEQ_ABORT_EN undefined: no abort port; a command always runs to completion.

Test Plan:
- lsl (op 18), cmd_b=0x0001, count 4 -> 4 consecutive alu_execute pulses T+1..T+4; rsp_valid at T+6; rsp_data=0x0010; Z=0.
- add (op 1), A=0x0003, B=0x0004, count 9 -> exactly one execute pulse; rsp_data=0x0007; flags C=0, Z=0, S=0.
- clear-carry (op 23), then rorc (op 20), B=0x8001, count 0 (16 steps) -> 16 pulses; rsp_data=0x0002; C=1.
- lsr (op 17), B=0xFFFF, count 1, rsp_ready held low 3 cycles -> rsp_valid and rsp_data=0x7FFF stable for 4 cycles; cmd_ready=0 until the handshake, then 1 the cycle after.
- RSTb pulsed low during the 3rd step of an 8-step asr -> alu_execute=0 the same cycle; rsp_valid never asserts; cmd_ready=1 after reset release.
- (ALU_SEQ_ABORT_EN) abort during step 2 of a 5-step lsl of 0x0001 -> no further execute pulses; no rsp_valid; state IDLE; next command is accepted normally.
